tl_sensor: RTL and testbench
============================

Name: tl_sensor

Overview:
Vehicle-detector front end for the traffic-light controller. It produces the Ta/Tb traffic-present inputs that the next-state logic consumes.
- Takes raw, asynchronous, bouncy loop-detector inputs for street A and street B.
- Synchronizes and debounces each input.
- Stretches each output by a hold time so a light does not cut short between closely spaced cars.
- Two identical, independent channels.

Parameters:
DEB_CYC, 4, consecutive synchronized-high samples required to declare traffic present; legal range >=2.
HOLD_CYC, 8, consecutive synchronized-low samples required to declare traffic absent; legal range >=2.
CNT_W, 4, width of the per-channel debounce/hold counter; must satisfy 2^CNT_W > max(DEB_CYC, HOLD_CYC).

Ports:
clk  input  1  system clock; all state is updated on its rising edge.
reset_n  input  1  reset, asynchronous, active-low.
sa_raw  input  1  raw street-A detector, asynchronous to clk.
sb_raw  input  1  raw street-B detector, asynchronous to clk.
Ta  output  1  street-A traffic present, decoded from registered state only.
Tb  output  1  street-B traffic present, decoded from registered state only.

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-low. The clock port is named clk and the reset port is named reset_n.
- Reset values:
  - sync flops = 0
  - both channel states = ABSENT
  - counters = 0
  - Ta = Tb = 0
- Reset takes effect immediately, with no clock edge needed, including mid-operation.
- Synchronizer: each raw input passes through a 2-flop synchronizer. Its second-stage output is s.
- Per-channel FSM (2-bit encoding):
  - ABSENT = 00, ARM = 01, PRESENT = 11, HOLD = 10.
  - T = 1 in PRESENT and HOLD; T = 0 otherwise.
- ABSENT:
  - s=1 -> ARM, cnt=1.
  - Otherwise stay, cnt=0.
- ARM:
  - s=0 -> ABSENT, cnt=0. A glitch restarts the debounce.
  - s=1 and cnt==DEB_CYC-1 -> PRESENT, cnt=0.
  - s=1 otherwise -> cnt+1.
- PRESENT:
  - s=0 -> HOLD, cnt=1.
  - Otherwise stay.
- HOLD:
  - s=1 -> PRESENT, cnt=0. A car returning during hold needs no re-debounce.
  - s=0 and cnt==HOLD_CYC-1 -> ABSENT, cnt=0.
  - s=0 otherwise -> cnt+1.
- Rise latency: raw high, first sampled at edge 0, gives T high after edge DEB_CYC+1 (2 sync edges + DEB_CYC count edges).
- Fall latency: raw low, first sampled at edge 0, gives T low after edge HOLD_CYC+1.
- The counter never exceeds max(DEB_CYC, HOLD_CYC)-1. No wrap-around is possible.
- Channels are fully independent. Simultaneous events on A and B are handled in the same cycle with no interaction.
- No combinational path from sa_raw/sb_raw to Ta/Tb.

Optional Feature:
Macro: TL_SENSOR_CNT_EN.
- Defined:
  - Adds output ports ca_cnt and cb_cnt, each 8 bits, reset to 0.
  - A channel's count increments by 1 on every ARM->PRESENT transition. A HOLD->PRESENT re-entry does not count.
  - The count saturates at 255 and never wraps.
- Undefined: the ports and counters are absent. Ta/Tb behaviour is identical in both builds.

Decomposition:
- Shared package tl_pkg holds:
  - the state encoding constants ST_ABSENT, ST_ARM, ST_PRESENT, ST_HOLD;
  - default DEB_CYC and HOLD_CYC values;
  - the car-count width constant (8).
- Sub-module tl_sensor_ch contains one channel: synchronizer, FSM, counter and optional car counter.
- tl_sensor instantiates tl_sensor_ch twice (A and B).

Test Plan:
- Reset: hold reset_n=0 with sa_raw=1 for 10 cycles -> Ta=Tb=0 throughout. Release, keep sa_raw=1 -> Ta rises after exactly the 6th rising edge following release (DEB_CYC=4).
- Glitch: sa_raw=1 for 3 cycles, then 0 -> Ta stays 0. The channel returns to ABSENT, and a later 4-cycle debounce starts from cnt=1.
- Hold: sa_raw=1 for 20 cycles, then 0 -> Ta stays 1 and falls after the 10th edge following the raw fall (HOLD_CYC=8). Tb stays 0 throughout.
- Return during hold: after Ta=1, drive sa_raw=0 for 5 cycles, then 1 -> Ta never drops. The FSM goes HOLD->PRESENT.
- Mid-operation reset: assert reset_n=0 asynchronously while channel A is in HOLD and B in ARM -> Ta=Tb=0 before the next clk edge. Both channels are ABSENT after release.
- With TL_SENSOR_CNT_EN: 3 debounced arrivals on A and 300 on B, with the hold/return case mixed in -> ca_cnt=3, cb_cnt=255 (saturated).

Source files
------------

// File: rtl/tl_pkg.sv
// tl_pkg: state encoding, default debounce/hold lengths and car-count width for tl_sensor.
package tl_pkg;
    typedef enum logic [1:0] {
        ST_ABSENT  = 2'b00,
        ST_ARM     = 2'b01,
        ST_PRESENT = 2'b11,
        ST_HOLD    = 2'b10
    } tl_state_t;
    localparam int DEB_CYC_DEF  = 4;
    localparam int HOLD_CYC_DEF = 8;
    localparam int CAR_W        = 8;
endpackage

// File: rtl/tl_sensor_ch.sv
// tl_sensor_ch: one detector channel (2-flop sync, debounce/hold FSM); TL_SENSOR_CNT_EN adds a saturating car counter.
module tl_sensor_ch
    import tl_pkg::*;
#(
    parameter int DEB_CYC  = DEB_CYC_DEF,
    parameter int HOLD_CYC = HOLD_CYC_DEF,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             raw,
    output logic             t
`ifdef TL_SENSOR_CNT_EN
    ,
    output logic [CAR_W-1:0] car_cnt
`endif
);
    logic [1:0]       sync;
    logic             s;
    tl_state_t        state;
    logic [CNT_W-1:0] cnt;
    assign s = sync[1];
    assign t = (state == ST_PRESENT) || (state == ST_HOLD);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync  <= '0;
            state <= ST_ABSENT;
            cnt   <= '0;
`ifdef TL_SENSOR_CNT_EN
            car_cnt <= '0;
`endif
        end else begin
            sync <= {sync[0], raw};
            case (state)
                ST_ABSENT: begin
                    state <= s ? ST_ARM : ST_ABSENT;
                    cnt   <= s ? CNT_W'(1) : '0;
                end
                ST_ARM: begin
                    if (!s) begin
                        state <= ST_ABSENT;
                        cnt   <= '0;
                    end else if (cnt == CNT_W'(DEB_CYC - 1)) begin
                        state <= ST_PRESENT;
                        cnt   <= '0;
`ifdef TL_SENSOR_CNT_EN
                        car_cnt <= (car_cnt == '1) ? car_cnt : car_cnt + CAR_W'(1);
`endif
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_PRESENT: begin
                    if (!s) begin
                        state <= ST_HOLD;
                        cnt   <= CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    // a returning car skips re-debounce and is not a new arrival
                    if (s) begin
                        state <= ST_PRESENT;
                        cnt   <= '0;
                    end else if (cnt == CNT_W'(HOLD_CYC - 1)) begin
                        state <= ST_ABSENT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end
endmodule

// File: rtl/tl_sensor.sv
// tl_sensor: debounced, hold-stretched Ta/Tb for streets A and B; TL_SENSOR_CNT_EN adds ca_cnt/cb_cnt car counts.
module tl_sensor
    import tl_pkg::*;
#(
    parameter int DEB_CYC  = DEB_CYC_DEF,
    parameter int HOLD_CYC = HOLD_CYC_DEF,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sa_raw,
    input  logic             sb_raw,
    output logic             Ta,
    output logic             Tb
`ifdef TL_SENSOR_CNT_EN
    ,
    output logic [CAR_W-1:0] ca_cnt,
    output logic [CAR_W-1:0] cb_cnt
`endif
);
    tl_sensor_ch #(.DEB_CYC(DEB_CYC), .HOLD_CYC(HOLD_CYC), .CNT_W(CNT_W)) u_a (
        .clk(clk),
        .reset_n(reset_n),
        .raw(sa_raw),
        .t(Ta)
`ifdef TL_SENSOR_CNT_EN
        ,
        .car_cnt(ca_cnt)
`endif
    );
    tl_sensor_ch #(.DEB_CYC(DEB_CYC), .HOLD_CYC(HOLD_CYC), .CNT_W(CNT_W)) u_b (
        .clk(clk),
        .reset_n(reset_n),
        .raw(sb_raw),
        .t(Tb)
`ifdef TL_SENSOR_CNT_EN
        ,
        .car_cnt(cb_cnt)
`endif
    );
endmodule

// File: tb/tb_tl_sensor.sv
// tb_tl_sensor: directed and randomized checks of tl_sensor against a streak-counting reference model.
module tb_tl_sensor;
    localparam int DEB  = 4;
    localparam int HOLD = 8;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic sa_raw = 1'b0;
    logic sb_raw = 1'b0;
    logic Ta, Tb;
`ifdef TL_SENSOR_CNT_EN
    logic [7:0] ca_cnt, cb_cnt;
`endif
    int n_tests = 0;
    int n_fail = 0;
    // model: raw delayed two samples, then presence decided by run lengths of equal samples
    bit p0[2], p1[2], pres[2];
    int streak[2], cars[2];

    tl_sensor #(.DEB_CYC(DEB), .HOLD_CYC(HOLD), .CNT_W(4)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .sa_raw(sa_raw),
        .sb_raw(sb_raw),
        .Ta(Ta),
        .Tb(Tb)
`ifdef TL_SENSOR_CNT_EN
        ,
        .ca_cnt(ca_cnt),
        .cb_cnt(cb_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        for (int c = 0; c < 2; c++) begin
            p0[c] = 0; p1[c] = 0; pres[c] = 0; streak[c] = 0; cars[c] = 0;
        end
    endtask

    task automatic model_step(input bit a, input bit b);
        bit r[2];
        bit s;
        r[0] = a; r[1] = b;
        for (int c = 0; c < 2; c++) begin
            s = p1[c];
            p1[c] = p0[c];
            p0[c] = r[c];
            if (!pres[c]) begin
                streak[c] = s ? streak[c] + 1 : 0;
                if (streak[c] == DEB) begin
                    pres[c] = 1; streak[c] = 0;
                    if (cars[c] < 255) cars[c]++;
                end
            end else begin
                streak[c] = s ? 0 : streak[c] + 1;
                if (streak[c] == HOLD) begin
                    pres[c] = 0; streak[c] = 0;
                end
            end
        end
    endtask

    task automatic tick(input logic a, input logic b);
        @(negedge clk);
        sa_raw = a;
        sb_raw = b;
        @(posedge clk);
        if (reset_n) model_step(a, b);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        sa_raw = 1'b0;
        sb_raw = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        int edge_n;
        reset_n = 1'b0;
        model_clear();
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 1'b0);
            n_tests++;
            if (Ta !== 1'b0 || Tb !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold cyc %0d: Ta=%b Tb=%b, need 0 0", i, Ta, Tb);
            end
        end
        reset_n = 1'b1;
        edge_n = 0;
        for (int i = 1; i <= 12; i++) begin
            tick(1'b1, 1'b0);
            if (Ta === 1'b1 && edge_n == 0) edge_n = i;
            n_tests++;
            if (Ta !== pres[0] || Tb !== pres[1]) begin
                n_fail++;
                $display("FAIL reset_release edge %0d: Ta=%b Tb=%b, need %b %b", i, Ta, Tb, pres[0], pres[1]);
            end
        end
        n_tests++;
        if (edge_n !== DEB + 2) begin
            n_fail++;
            $display("FAIL reset_rise_latency: rose at edge %0d, need %0d", edge_n, DEB + 2);
        end
    endtask

    task automatic test_glitch();
        int edge_n;
        do_reset();
        for (int i = 0; i < 13; i++) begin
            tick(i < 3, 1'b0);
            n_tests++;
            if (Ta !== 1'b0 || Ta !== pres[0]) begin
                n_fail++;
                $display("FAIL glitch cyc %0d: Ta=%b, need 0", i, Ta);
            end
        end
        edge_n = 0;
        for (int i = 1; i <= 12; i++) begin
            tick(1'b1, 1'b0);
            if (Ta === 1'b1 && edge_n == 0) edge_n = i;
        end
        n_tests++;
        if (edge_n !== DEB + 2) begin
            n_fail++;
            $display("FAIL glitch_redebounce: rose at edge %0d, need %0d", edge_n, DEB + 2);
        end
    endtask

    task automatic test_hold();
        int edge_n;
        do_reset();
        for (int i = 0; i < 20; i++) tick(1'b1, 1'b0);
        n_tests++;
        if (Ta !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_present: Ta=%b, need 1", Ta);
        end
        edge_n = 0;
        for (int i = 1; i <= 16; i++) begin
            tick(1'b0, 1'b0);
            if (Ta === 1'b0 && edge_n == 0) edge_n = i;
            n_tests++;
            if (Ta !== pres[0] || Tb !== 1'b0) begin
                n_fail++;
                $display("FAIL hold edge %0d: Ta=%b Tb=%b, need %b 0", i, Ta, Tb, pres[0]);
            end
        end
        n_tests++;
        if (edge_n !== HOLD + 2) begin
            n_fail++;
            $display("FAIL hold_fall_latency: fell at edge %0d, need %0d", edge_n, HOLD + 2);
        end
    endtask

    task automatic test_return();
        do_reset();
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick(!(i < 5), 1'b0);
            n_tests++;
            if (Ta !== 1'b1 || Tb !== 1'b0) begin
                n_fail++;
                $display("FAIL return cyc %0d: Ta=%b Tb=%b, need 1 0", i, Ta, Tb);
            end
        end
    endtask

    task automatic test_mid_reset();
        int ea, eb;
        do_reset();
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
        #2;
        n_tests++;
        if (Ta !== 1'b1 || Tb !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_pre: Ta=%b Tb=%b, need 1 0", Ta, Tb);
        end
        reset_n = 1'b0;
        model_clear();
        #1;
        n_tests++;
        if (Ta !== 1'b0 || Tb !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_async: Ta=%b Tb=%b, need 0 0", Ta, Tb);
        end
        tick(1'b0, 1'b1);
        reset_n = 1'b1;
        ea = 0;
        eb = 0;
        for (int i = 1; i <= 12; i++) begin
            tick(1'b1, 1'b1);
            if (Ta === 1'b1 && ea == 0) ea = i;
            if (Tb === 1'b1 && eb == 0) eb = i;
        end
        n_tests++;
        if (ea !== DEB + 2 || eb !== DEB + 2) begin
            n_fail++;
            $display("FAIL midreset_after: rise edges A=%0d B=%0d, need %0d", ea, eb, DEB + 2);
        end
    endtask

    task automatic test_random();
        int ra, rb;
        logic a, b;
        do_reset();
        ra = 0; rb = 0; a = 0; b = 0;
        for (int i = 0; i < 3000; i++) begin
            if (ra == 0) begin a = 1'($urandom_range(0, 1)); ra = $urandom_range(1, 12); end
            if (rb == 0) begin b = 1'($urandom_range(0, 1)); rb = $urandom_range(1, 12); end
            tick(a, b);
            ra--;
            rb--;
            n_tests++;
            if (Ta !== pres[0] || Tb !== pres[1]) begin
                n_fail++;
                $display("FAIL random cyc %0d: Ta=%b Tb=%b, need %b %b", i, Ta, Tb, pres[0], pres[1]);
            end
        end
`ifdef TL_SENSOR_CNT_EN
        n_tests++;
        if (ca_cnt !== 8'(cars[0]) || cb_cnt !== 8'(cars[1])) begin
            n_fail++;
            $display("FAIL random_cars: ca=%0d cb=%0d, need %0d %0d", ca_cnt, cb_cnt, cars[0], cars[1]);
        end
`endif
    endtask

`ifdef TL_SENSOR_CNT_EN
    task automatic test_car_count();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 6; i++) tick(1'b1, 1'b0);
            if (k == 1) begin
                for (int i = 0; i < 4; i++) tick(1'b0, 1'b0);
                for (int i = 0; i < 4; i++) tick(1'b1, 1'b0);
            end
            for (int i = 0; i < 12; i++) tick(1'b0, 1'b0);
        end
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < 5; i++) tick(1'b0, 1'b1);
            for (int i = 0; i < 10; i++) tick(1'b0, 1'b0);
        end
        n_tests++;
        if (ca_cnt !== 8'd3 || cars[0] != 3) begin
            n_fail++;
            $display("FAIL car_count_a: ca_cnt=%0d, need 3", ca_cnt);
        end
        n_tests++;
        if (cb_cnt !== 8'd255 || cars[1] != 255) begin
            n_fail++;
            $display("FAIL car_count_b: cb_cnt=%0d, need 255", cb_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_glitch();
        test_hold();
        test_return();
        test_mid_reset();
        test_random();
`ifdef TL_SENSOR_CNT_EN
        test_car_count();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
